// File: rtl/qerv_rf_ram_resp_if.sv
// Core RF RAM port plus debug word port. The slave modport is the RAM-side responder,
// the master modport is the core/debug requester side.
interface qerv_rf_ram_resp_if #(
  parameter int unsigned width = 8,
  parameter int unsigned aw    = 8
);
  logic [aw-1:0]    i_waddr;
  logic [width-1:0] i_wdata;
  logic             i_wen;
  logic [aw-1:0]    i_raddr;
  logic             i_ren;
  logic [width-1:0] o_rdata;
  logic             o_init_done;
  logic             i_dbg_req;
  logic             i_dbg_we;
  logic [aw-1:0]    i_dbg_addr;
  logic [width-1:0] i_dbg_wdata;
  logic             o_dbg_ack;
  logic [width-1:0] o_dbg_rdata;

  modport slave (
    input  i_waddr, i_wdata, i_wen, i_raddr, i_ren,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    output o_rdata, o_init_done, o_dbg_ack, o_dbg_rdata
  );

  modport master (
    output i_waddr, i_wdata, i_wen, i_raddr, i_ren,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    input  o_rdata, o_init_done, o_dbg_ack, o_dbg_rdata
  );
endinterface

// File: rtl/qerv_rf_ram_resp.sv
// Register-file RAM responder: 1-cycle core reads, idle-cycle debug word access and,
// with QERV_RF_RAM_CLEAR_EN defined, a post-reset zero-fill of the whole array.
module qerv_rf_ram_resp #(
  parameter int unsigned width    = 8,
  parameter int unsigned csr_regs = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  qerv_rf_ram_resp_if.slave bus
);
  localparam int unsigned raw   = $clog2(32 + csr_regs);
  localparam int unsigned l2w   = $clog2(width);
  localparam int unsigned aw    = 5 + raw - l2w;
  localparam int unsigned depth = 2 ** aw;

  typedef enum logic [1:0] {StClear, StIdle, StDbgRd, StDbgAck} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [width-1:0] r_mem [depth];
  logic [width-1:0] r_rdata;
  logic [width-1:0] r_dbg_buf;
  logic [width-1:0] r_dbg_rdata;
  logic             w_dbg_grant;
  logic             w_core_rd;
  logic             w_mem_we;
  logic [aw-1:0]    w_mem_waddr;
  logic [width-1:0] w_mem_wdata;
  logic             w_clr_last;
  logic [aw-1:0]    w_clr_addr;

`ifdef QERV_RF_RAM_CLEAR_EN
  localparam state_e ResetState = StClear;
  logic [aw-1:0] r_clr_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clr_cnt <= '0;
    end else if (r_state == StClear) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign w_clr_last       = &r_clr_cnt;
  assign w_clr_addr       = r_clr_cnt;
  assign bus.o_init_done  = (r_state != StClear);
`else
  localparam state_e ResetState = StIdle;
  assign w_clr_last       = 1'b0;
  assign w_clr_addr       = '0;
  assign bus.o_init_done  = 1'b1;
`endif

  assign w_core_rd = bus.i_ren && (r_state != StClear);

  // Single write port: clear fill, core write, or a debug write granted on a core-idle cycle.
  always_comb begin
    w_state_next = r_state;
    w_dbg_grant  = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_waddr  = bus.i_waddr;
    w_mem_wdata  = bus.i_wdata;
    case (r_state)
      StClear: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = w_clr_addr;
        w_mem_wdata = '0;
        if (w_clr_last) w_state_next = StIdle;
      end
      StIdle: begin
        w_mem_we = bus.i_wen;
        if (bus.i_dbg_req && !bus.i_wen && !bus.i_ren) begin
          w_dbg_grant  = 1'b1;
          w_state_next = bus.i_dbg_we ? StDbgAck : StDbgRd;
          w_mem_we     = bus.i_dbg_we;
          w_mem_waddr  = bus.i_dbg_addr;
          w_mem_wdata  = bus.i_dbg_wdata;
        end
      end
      StDbgRd: begin
        w_mem_we     = bus.i_wen;
        w_state_next = StDbgAck;
      end
      StDbgAck: begin
        w_mem_we     = bus.i_wen;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ResetState;
      r_rdata     <= '0;
      r_dbg_buf   <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_core_rd) r_rdata <= r_mem[bus.i_raddr];
      // Debug read data is sampled at grant and published one cycle later with the ack.
      if (w_dbg_grant && !bus.i_dbg_we) r_dbg_buf <= r_mem[bus.i_dbg_addr];
      if (r_state == StDbgRd) r_dbg_rdata <= r_dbg_buf;
    end
  end

  assign bus.o_rdata     = r_rdata;
  assign bus.o_dbg_ack   = (r_state == StDbgAck);
  assign bus.o_dbg_rdata = r_dbg_rdata;
endmodule

// File: tb/tb_qerv_rf_ram_resp.sv
// Self-checking bench for qerv_rf_ram_resp: vector table, hand-written debug/reset sequences
// and a randomized phase against a word-level memory model.
module tb_qerv_rf_ram_resp;
  localparam int unsigned W     = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qerv_rf_ram_resp_if #(.width(W), .aw(AW)) bus ();

  qerv_rf_ram_resp #(.width(8), .csr_regs(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_rdata;
  logic [7:0] m_dbg_rdata;

  typedef struct {
    logic       wen;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       ren;
    logic [7:0] raddr;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

`ifdef QERV_RF_RAM_CLEAR_EN
  localparam logic InitDoneRst = 1'b0;
`else
  localparam logic InitDoneRst = 1'b1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdata"}, bus.o_rdata, 8'h00);
    chk({tag, "_ack"}, bus.o_dbg_ack, 1'b0);
    chk({tag, "_dbg_rdata"}, bus.o_dbg_rdata, 8'h00);
    chk({tag, "_init_done"}, bus.o_init_done, InitDoneRst);
  endtask

  // One core cycle, model applied read-first.
  task automatic core_op(input logic wen, input logic [7:0] wa, input logic [7:0] wd,
                         input logic ren, input logic [7:0] ra);
    bus.i_wen = wen; bus.i_waddr = wa; bus.i_wdata = wd;
    bus.i_ren = ren; bus.i_raddr = ra;
    step();
    if (ren) m_rdata = m_mem[ra];
    if (wen) m_mem[wa] = wd;
    chk("core_rdata", bus.o_rdata, m_rdata);
    bus.i_wen = 1'b0;
    bus.i_ren = 1'b0;
  endtask

  // Debug access with the core idle; returns cycles from request to ack.
  task automatic dbg_access(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                            output int lat);
    lat = 0;
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = we; bus.i_dbg_addr = addr; bus.i_dbg_wdata = wd;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (bus.o_dbg_ack) begin
        lat = i;
        break;
      end
    end
    bus.i_dbg_req = 1'b0;
    chk("dbg_ack_seen", bus.o_dbg_ack, 1'b1);
    if (we) m_mem[addr] = wd;
    else    m_dbg_rdata = m_mem[addr];
    chk("dbg_rdata", bus.o_dbg_rdata, m_dbg_rdata);
    step();
    chk("dbg_ack_one_cycle", bus.o_dbg_ack, 1'b0);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      bus.i_wen = 1'b1; bus.i_waddr = 8'($urandom); bus.i_wdata = 8'hFF;
      bus.i_ren = 1'b1; bus.i_raddr = 8'($urandom);
      step();
      if (bus.o_init_done) begin
        n = k;
        break;
      end
    end
    bus.i_wen = 1'b0;
    bus.i_ren = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    logic [7:0] saved;
    logic pend;
    int wait_cnt;
    logic d_we;
    logic [7:0] d_addr, d_wd;
    logic c_wen, c_ren;
    logic [7:0] c_wa, c_wd, c_ra;

    bus.i_wen = 1'b0; bus.i_waddr = '0; bus.i_wdata = '0;
    bus.i_ren = 1'b0; bus.i_raddr = '0;
    bus.i_dbg_req = 1'b0; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = '0; bus.i_dbg_wdata = '0;
    m_rdata = 8'h00;
    m_dbg_rdata = 8'h00;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

    vecs[0] = '{1'b1, 8'h12, 8'hA5, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h12, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 8'h30, 8'h11, 1'b0, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 8'h30, 8'h22, 1'b1, 8'h30, 8'h11};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 8'h22};
    vecs[6] = '{1'b1, 8'h40, 8'h99, 1'b1, 8'h12, 8'hA5};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 8'h99};
    vecs[8] = '{1'b1, 8'h12, 8'h5A, 1'b1, 8'h40, 8'h99};

    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;

`ifdef QERV_RF_RAM_CLEAR_EN
    repeat (100) step();
    chk("clear_busy_c100", bus.o_init_done, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_clear");
    step();
    rst_n = 1'b1;
    wait_init(n);
    chk("clear_cycles", n, 256);
    chk("rdata_held_in_clear", bus.o_rdata, 8'h00);
    for (int a = 0; a < DEPTH; a++) core_op(1'b0, 8'h00, 8'h00, 1'b1, 8'(a));
`else
    chk("init_done_tied", bus.o_init_done, 1'b1);
    for (int a = 0; a < DEPTH; a++) core_op(1'b1, 8'(a), 8'h00, 1'b0, 8'h00);
`endif

    for (int i = 0; i < 9; i++) begin
      core_op(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].ren, vecs[i].raddr);
      chk($sformatf("vec%0d_rdata", i), bus.o_rdata, vecs[i].exp_rdata);
    end

    // Debug write held off by continuous core traffic.
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b1; bus.i_dbg_addr = 8'h05; bus.i_dbg_wdata = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      c_ren = (i % 2 == 0);
      c_ra = 8'($urandom_range(8'h10, 8'h50));
      bus.i_ren = c_ren; bus.i_raddr = c_ra;
      bus.i_wen = !c_ren; bus.i_waddr = 8'(8'h80 + i); bus.i_wdata = 8'(i);
      step();
      if (c_ren) m_rdata = m_mem[c_ra];
      else       m_mem[8'h80 + i] = 8'(i);
      chk("busy_rdata", bus.o_rdata, m_rdata);
      chk("dbg_blocked", bus.o_dbg_ack, 1'b0);
    end
    bus.i_ren = 1'b0; bus.i_wen = 1'b0;
    step();
    chk("dbg_wr_ack_lat1", bus.o_dbg_ack, 1'b1);
    bus.i_dbg_req = 1'b0;
    m_mem[8'h05] = 8'h3C;
    step();
    chk("dbg_wr_ack_drop", bus.o_dbg_ack, 1'b0);
    core_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h05);
    chk("dbg_wr_readback", bus.o_rdata, 8'h3C);

    // Debug read with idle core.
    core_op(1'b1, 8'hFF, 8'h7E, 1'b0, 8'h00);
    core_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h40);
    saved = m_rdata;
    dbg_access(1'b0, 8'hFF, 8'h00, lat);
    chk("dbg_rd_lat", lat, 2);
    chk("dbg_rd_val", bus.o_dbg_rdata, 8'h7E);
    chk("rdata_undisturbed", bus.o_rdata, saved);
    dbg_access(1'b1, 8'h21, 8'hC3, lat);
    chk("dbg_wr_lat", lat, 1);

    // Request held through ack re-triggers a second transaction.
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b1; bus.i_dbg_addr = 8'h22; bus.i_dbg_wdata = 8'h44;
    step();
    chk("hold_ack1", bus.o_dbg_ack, 1'b1);
    step();
    chk("hold_gap", bus.o_dbg_ack, 1'b0);
    step();
    chk("hold_ack2", bus.o_dbg_ack, 1'b1);
    bus.i_dbg_req = 1'b0;
    m_mem[8'h22] = 8'h44;
    step();
    chk("hold_done", bus.o_dbg_ack, 1'b0);
    chk("dbg_rdata_held", bus.o_dbg_rdata, 8'h7E);

    // Reset after traffic: outputs clear, storage is not reset.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_op");
    m_rdata = 8'h00;
    m_dbg_rdata = 8'h00;
    step();
    rst_n = 1'b1;
`ifdef QERV_RF_RAM_CLEAR_EN
    wait_init(n);
    chk("reclear_cycles", n, 256);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
`endif
    core_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h22);

    // Randomized mixed traffic; core never touches the pending debug address.
    pend = 1'b0;
    wait_cnt = 0;
    d_we = 1'b0; d_addr = 8'h00; d_wd = 8'h00;
    for (int c = 0; c < 620; c++) begin
      if (c < 600 && !pend && ($urandom % 6 == 0)) begin
        pend = 1'b1; wait_cnt = 0;
        d_we = 1'($urandom); d_addr = 8'($urandom); d_wd = 8'($urandom);
        bus.i_dbg_req = 1'b1; bus.i_dbg_we = d_we;
        bus.i_dbg_addr = d_addr; bus.i_dbg_wdata = d_wd;
      end
      c_wen = (c < 600) && 1'($urandom);
      c_ren = (c < 600) && 1'($urandom);
      c_wa = 8'($urandom); c_wd = 8'($urandom); c_ra = 8'($urandom);
      if (pend && c_wa == d_addr) c_wa = c_wa ^ 8'h01;
      if (pend && c_ra == d_addr) c_ra = c_ra ^ 8'h01;
      bus.i_wen = c_wen; bus.i_waddr = c_wa; bus.i_wdata = c_wd;
      bus.i_ren = c_ren; bus.i_raddr = c_ra;
      step();
      if (c_ren) m_rdata = m_mem[c_ra];
      if (c_wen) m_mem[c_wa] = c_wd;
      chk("rnd_ack_allowed", bus.o_dbg_ack & ~pend, 1'b0);
      if (bus.o_dbg_ack && pend) begin
        if (d_we) m_mem[d_addr] = d_wd;
        else      m_dbg_rdata = m_mem[d_addr];
        pend = 1'b0;
        bus.i_dbg_req = 1'b0;
      end else if (pend) begin
        wait_cnt++;
        if (wait_cnt > 200) begin
          chk("rnd_dbg_timeout", bus.o_dbg_ack, 1'b1);
          pend = 1'b0;
          bus.i_dbg_req = 1'b0;
        end
      end
      chk("rnd_rdata", bus.o_rdata, m_rdata);
      chk("rnd_dbg_rdata", bus.o_dbg_rdata, m_dbg_rdata);
    end
    chk("rnd_drained", {31'd0, pend}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qerv_rf_ram_resp.md
Name: qerv_rf_ram_resp

Overview:
RAM-side responder for the bit-serial register-file RAM interface. It owns the register-file storage and serves the controller's write port (waddr/wdata/wen) and read port (raddr/ren/rdata) with fixed 1-cycle read latency. It adds a post-reset clear sequencer and a low-priority debug word-access port that uses idle cycles. It sits between the core's RF RAM interface and the SoC debug/loader logic.

Parameters:
width, 8, RAM data width; must match the controller (2, 4, 8, 16 or 32)
csr_regs, 4, CSR registers placed after the 32 GPRs
raw, $clog2(32+csr_regs), register address width (derived, do not override)
l2w, $clog2(width), log2 of width (derived)
aw, 5+raw-l2w, RAM address width (derived); depth = 2**aw words

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_waddr  in  aw  core write address
i_wdata  in  width  core write data
i_wen  in  1  core write enable
i_raddr  in  aw  core read address
i_ren  in  1  core read enable
o_rdata  out  width  core read data, registered
o_init_done  out  1  high once storage is valid; core must not issue requests before this
i_dbg_req  in  1  debug request, held until o_dbg_ack
i_dbg_we  in  1  debug 1=write, 0=read; stable while i_dbg_req high
i_dbg_addr  in  aw  debug word address; stable while i_dbg_req high
i_dbg_wdata  in  width  debug write data; stable while i_dbg_req high
o_dbg_ack  out  1  single-cycle completion pulse
o_dbg_rdata  out  width  debug read data, valid with o_dbg_ack, held until next read ack

Behaviour:
- Reset (async assert, sync release): o_rdata=0, o_dbg_ack=0, o_dbg_rdata=0, o_init_done=0 (1 without the optional feature), FSM=CLEAR (IDLE without the feature), clear counter=0. Storage array is not reset.
- FSM states: CLEAR, IDLE, DBG_RD, DBG_ACK.
- CLEAR: writes 0 to address = counter each cycle; counter increments 0..2**aw-1. After the write to the last address, the next state is IDLE and o_init_done goes high on the same edge. Default config needs 256 clear cycles, so o_init_done rises at cycle 256 after reset release.
- In CLEAR, core i_wen/i_ren are ignored and o_rdata holds. i_dbg_req waits.
- Reset mid-CLEAR: the clear restarts from address 0.
- Core write: when i_wen and not in CLEAR, mem[i_waddr] <= i_wdata at the edge.
- Core read: when i_ren and not in CLEAR, o_rdata <= mem[i_raddr] at the edge, so latency is 1 cycle. With i_ren low, o_rdata holds its value.
- Read/write to the same address in the same cycle: read-first, so o_rdata returns the old contents.
- Core i_wen and i_ren in the same cycle to different addresses: both are served.
- Debug grant: only in IDLE, only when i_dbg_req=1 and i_wen=0 and i_ren=0. The core always has priority; a blocked debug request waits indefinitely with no timeout.
- Debug write grant: mem[i_dbg_addr] <= i_dbg_wdata; next state is DBG_ACK.
- Debug read grant: the read is issued; next state is DBG_RD.
- DBG_RD: o_dbg_rdata <= read data; next state is DBG_ACK. The debug read does not disturb o_rdata.
- In DBG_RD and DBG_ACK, core writes are still honoured. A core read in DBG_RD is also honoured; the debug read data was already captured on the granting edge.
- DBG_ACK: o_dbg_ack=1 for exactly one cycle, then IDLE.
- Debug latency with no core traffic:
  - write: ack 1 cycle after grant
  - read: ack 2 cycles after grant
- i_dbg_req still high on the cycle after ack starts a new transaction. The requester must drop it in the ack cycle to avoid a repeat.
- Address wrap: addresses are aw bits and taken modulo 2**aw; no range check.

Optional Feature:
QERV_RF_RAM_CLEAR_EN
- Defined: CLEAR state and counter are present; o_init_done resets to 0 and rises after the full zero-fill. This guarantees x0 and all GPRs/CSRs read as 0.
- Undefined: no clear logic; FSM resets to IDLE, o_init_done is tied 1, and storage contents are undefined until written.

Test Plan:
- Clear: feature on, default params, release reset -> o_init_done=0 for 256 cycles then 1; a read of every address returns 0x00.
- Core write/read: write 0xA5 to addr 0x12, then i_ren on addr 0x12 -> o_rdata=0xA5 one cycle later and held while i_ren low.
- Same-address RW: mem[0x30]=0x11; same cycle i_wen 0x30 data 0x22 and i_ren 0x30 -> o_rdata=0x11; next read -> 0x22.
- Debug vs core: assert i_dbg_req write 0x3C to 0x05 while i_ren toggles every cycle for 10 cycles -> no grant until the first idle cycle; o_dbg_ack 1 cycle after grant; core read of 0x05 -> 0x3C.
- Debug read: mem[0xFF]=0x7E, debug read 0xFF with core idle -> o_dbg_ack 2 cycles after req; o_dbg_rdata=0x7E; o_rdata unchanged.
- Reset mid-clear: deassert i_rst_n at clear cycle 100 -> all outputs reset immediately; on release o_init_done rises 256 cycles later.
